intersection_phase_scheduler: RTL and testbench

- Round-robin phase scheduler that shares one intersection between NUM_APP approaches. Each approach has its own car sensor; the intersection also takes one pedestrian request and one directed emergency preemption.
- Grants green to exactly one approach at a time. Sequences yellow and all-red clearance between grants, inserts pedestrian phases and preempts for emergency vehicles.
- Sits above the per-approach signal heads and drives their green/yellow enables directly.

---
 rtl/intersection_phase_scheduler.sv | 167 ++++++++++++++++
 tb/tb_intersection_phase_scheduler.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/intersection_phase_scheduler.sv
// Round-robin intersection phase scheduler: green/yellow/all-red sequencing, pedestrian phases, emergency preemption.
// Outputs decode the registered state (no added latency); demand inputs are levels with no backpressure.
module intersection_phase_scheduler #(
  parameter int NUM_APP   = 4,
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 10,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int PED_T     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_APP-1:0] car_req,
  input  logic               ped_req,
  input  logic               emergency,
  input  logic [1:0]         emergency_dir,
  output logic [NUM_APP-1:0] grant_green,
  output logic [NUM_APP-1:0] grant_yellow,
  output logic               pedestrian_green,
  output logic               emergency_active,
  output logic [1:0]         active_dir,
  output logic [2:0]         phase_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GREEN   = 3'd1,
    YELLOW  = 3'd2,
    ALL_RED = 3'd3,
    PED     = 3'd4,
    EMERG   = 3'd5
  } phase_t;

  localparam logic [3:0] MIN_LAST    = 4'(MIN_GREEN - 1);
  localparam logic [3:0] MAX_LAST    = 4'(MAX_GREEN - 1);
  localparam logic [3:0] YELLOW_LAST = 4'(YELLOW_T - 1);
  localparam logic [3:0] ALLRED_LAST = 4'(ALLRED_T - 1);
  localparam logic [3:0] PED_LAST    = 4'(PED_T - 1);

  phase_t             state;
  phase_t             state_nxt;
  logic [3:0]         timer;
  logic [1:0]         rr_ptr;
  logic [1:0]         rr_nxt;
  logic [1:0]         dir_nxt;
  logic               ped_pending;
  logic [1:0]         rr_winner;
  logic               rr_hit;
  logic               decide;
  logic [NUM_APP-1:0] dir_mask;
  logic               other_req;

  assign dir_mask  = NUM_APP'(1) << active_dir;
  assign other_req = |(car_req & ~dir_mask);

  // First requesting approach strictly after the last one served.
  always_comb begin
    logic [1:0] cand;
    cand      = rr_ptr;
    rr_winner = rr_ptr;
    rr_hit    = 1'b0;
    for (int i = 1; i <= NUM_APP; i++) begin
      cand = rr_ptr + 2'(i);
      if (!rr_hit && car_req[cand]) begin
        rr_hit    = 1'b1;
        rr_winner = cand;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    dir_nxt   = active_dir;
    rr_nxt    = rr_ptr;
    decide    = 1'b0;
    case (state)
      IDLE: decide = 1'b1;
      GREEN: begin
        if (emergency && emergency_dir == active_dir) begin
          state_nxt = EMERG;
        end else if (emergency) begin
          state_nxt = YELLOW;
        end else if (timer == MAX_LAST) begin
          state_nxt = YELLOW;
        end else if (timer >= MIN_LAST &&
                     (!car_req[active_dir] || other_req || ped_pending)) begin
          state_nxt = YELLOW;
        end
      end
      YELLOW: begin
        if (timer == YELLOW_LAST) state_nxt = ALL_RED;
      end
      ALL_RED: begin
        if (timer == ALLRED_LAST) decide = 1'b1;
      end
      PED: begin
        if (timer == PED_LAST) state_nxt = ALL_RED;
      end
      EMERG: begin
        // Leaving preemption counts as having served this approach.
        if (!emergency) begin
          state_nxt = YELLOW;
          rr_nxt    = active_dir;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (decide) begin
      if (emergency) begin
        state_nxt = EMERG;
        dir_nxt   = emergency_dir;
      end else if (ped_pending) begin
        state_nxt = PED;
      end else if (rr_hit) begin
        state_nxt = GREEN;
        dir_nxt   = rr_winner;
        rr_nxt    = rr_winner;
      end else begin
        state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      timer       <= 4'd0;
      rr_ptr      <= 2'd3;
      ped_pending <= 1'b0;
      active_dir  <= 2'd0;
    end else begin
      state      <= state_nxt;
      active_dir <= dir_nxt;
      rr_ptr     <= rr_nxt;
      if (state_nxt != state) begin
        timer <= 4'd0;
      end else if (timer != 4'd15) begin
        timer <= timer + 4'd1;
      end
      if (state_nxt == PED && state != PED) begin
        ped_pending <= 1'b0;
      end else if (ped_req && state != PED) begin
        ped_pending <= 1'b1;
      end
    end
  end

  always_comb begin
    grant_green      = '0;
    grant_yellow     = '0;
    pedestrian_green = 1'b0;
    emergency_active = 1'b0;
    phase_state      = state;
    case (state)
      GREEN:  grant_green = dir_mask;
      YELLOW: grant_yellow = dir_mask;
      PED:    pedestrian_green = 1'b1;
      EMERG: begin
        grant_green      = dir_mask;
        emergency_active = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Bench for intersection_phase_scheduler: directed scenarios plus random traffic against a phase-level reference model.
module tb_intersection_phase_scheduler;

  localparam int MIN_GREEN = 4;
  localparam int MAX_GREEN = 10;
  localparam int YELLOW_T  = 2;
  localparam int ALLRED_T  = 1;
  localparam int PED_T     = 4;

  localparam int P_IDLE = 0, P_GREEN = 1, P_YELLOW = 2, P_ALLRED = 3, P_PED = 4, P_EMERG = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] car_req = '0;
  logic       ped_req = 1'b0;
  logic       emergency = 1'b0;
  logic [1:0] emergency_dir = '0;
  logic [3:0] grant_green;
  logic [3:0] grant_yellow;
  logic       pedestrian_green;
  logic       emergency_active;
  logic [1:0] active_dir;
  logic [2:0] phase_state;

  int n_checks = 0;
  int n_errors = 0;

  intersection_phase_scheduler #(
    .NUM_APP(4), .MIN_GREEN(MIN_GREEN), .MAX_GREEN(MAX_GREEN),
    .YELLOW_T(YELLOW_T), .ALLRED_T(ALLRED_T), .PED_T(PED_T)
  ) dut (
    .clk(clk), .reset(reset), .car_req(car_req), .ped_req(ped_req),
    .emergency(emergency), .emergency_dir(emergency_dir),
    .grant_green(grant_green), .grant_yellow(grant_yellow),
    .pedestrian_green(pedestrian_green), .emergency_active(emergency_active),
    .active_dir(active_dir), .phase_state(phase_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: which phase we are in, how many cycles it has run,
  // who was served last and whether a walk request is waiting.
  int  m_phase, m_age, m_last, m_dir;
  bit  m_ped;
  bit  chk_en = 1'b0;

  task model_step();
    int  nxt, ndir, nlast, cand;
    bit  decide, others;
    nxt = m_phase; ndir = m_dir; nlast = m_last; decide = 0;
    others = (car_req & ~(4'b0001 << m_dir)) != 0;
    case (m_phase)
      P_IDLE: decide = 1;
      P_GREEN: begin
        if (emergency && int'(emergency_dir) == m_dir) nxt = P_EMERG;
        else if (emergency) nxt = P_YELLOW;
        else if (m_age + 1 >= MAX_GREEN) nxt = P_YELLOW;
        else if (m_age + 1 >= MIN_GREEN && (!car_req[m_dir] || others || m_ped)) nxt = P_YELLOW;
      end
      P_YELLOW: if (m_age + 1 == YELLOW_T) nxt = P_ALLRED;
      P_ALLRED: if (m_age + 1 == ALLRED_T) decide = 1;
      P_PED:    if (m_age + 1 == PED_T) nxt = P_ALLRED;
      P_EMERG:  if (!emergency) begin nxt = P_YELLOW; nlast = m_dir; end
      default:  nxt = P_IDLE;
    endcase
    if (decide) begin
      if (emergency) begin
        nxt = P_EMERG; ndir = int'(emergency_dir);
      end else if (m_ped) begin
        nxt = P_PED;
      end else if (car_req != 0) begin
        for (int k = 1; k <= 4; k++) begin
          cand = (m_last + k) % 4;
          if (nxt != P_GREEN && car_req[cand]) begin
            nxt = P_GREEN; ndir = cand; nlast = cand;
          end
        end
      end else begin
        nxt = P_IDLE;
      end
    end
    if (nxt == P_PED && m_phase != P_PED) m_ped = 0;
    else if (ped_req && m_phase != P_PED) m_ped = 1;
    m_age   = (nxt == m_phase) ? m_age + 1 : 0;
    m_phase = nxt; m_dir = ndir; m_last = nlast;
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_phase = P_IDLE; m_age = 0; m_last = 3; m_ped = 0; m_dir = 0;
      chk_en = 1'b1;
    end else if (chk_en) begin
      model_step();
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [3:0] exp_g, exp_y;
      exp_g = (m_phase == P_GREEN || m_phase == P_EMERG) ? (4'b0001 << m_dir) : 4'b0000;
      exp_y = (m_phase == P_YELLOW) ? (4'b0001 << m_dir) : 4'b0000;
      chk("m_phase_state", 32'(phase_state), 32'(m_phase));
      chk("m_grant_green", 32'(grant_green), 32'(exp_g));
      chk("m_grant_yellow", 32'(grant_yellow), 32'(exp_y));
      chk("m_ped_green", 32'(pedestrian_green), 32'(m_phase == P_PED));
      chk("m_emerg_active", 32'(emergency_active), 32'(m_phase == P_EMERG));
      chk("m_active_dir", 32'(active_dir), 32'(m_dir));
    end
  end

  function automatic logic [3:0] sig(input int sel);
    case (sel)
      0:       return grant_green;
      1:       return grant_yellow;
      default: return {3'b000, pedestrian_green};
    endcase
  endfunction

  // Waits for the selected output to go nonzero, then counts how long it holds that value.
  task automatic measure(input int sel, output logic [3:0] val, output int len);
    val = '0; len = 0;
    for (int i = 0; i < 200 && sig(sel) == 4'd0; i++) @(negedge clk);
    if (sig(sel) == 4'd0) begin
      chk("measure_timeout", 32'd0, 32'd1);
      return;
    end
    val = sig(sel);
    for (int i = 0; i < 200 && sig(sel) == val; i++) begin
      len++;
      @(negedge clk);
    end
  endtask

  task automatic wait_gg(input logic [3:0] v);
    for (int i = 0; i < 100 && grant_green !== v; i++) @(negedge clk);
    chk("wait_green", 32'(grant_green), 32'(v));
  endtask

  task automatic do_reset();
    reset = 1'b1; car_req = '0; ped_req = 1'b0; emergency = 1'b0; emergency_dir = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] v;
    int         len;
    logic [3:0] rr_seq [5];
    rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    @(negedge clk);
    reset = 1'b0;
    chk("reset_green", 32'(grant_green), 32'd0);
    chk("reset_phase", 32'(phase_state), 32'd0);

    // Single approach under continuous demand runs to the maximum green.
    do_reset();
    car_req = 4'b0001;
    measure(0, v, len);
    chk("solo_val", 32'(v), 32'h1);
    chk("solo_len", 32'(len), 32'(MAX_GREEN));
    measure(1, v, len);
    chk("solo_yellow_len", 32'(len), 32'(YELLOW_T));
    measure(0, v, len);
    chk("solo_again_val", 32'(v), 32'h1);

    // All approaches busy: round robin with minimum greens.
    do_reset();
    car_req = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      measure(0, v, len);
      chk("rr_val", 32'(v), 32'(rr_seq[r]));
      chk("rr_len", 32'(len), 32'(MIN_GREEN));
    end

    // Pedestrian pulse during an early green.
    do_reset();
    car_req = 4'b0001;
    wait_gg(4'b0001);
    @(negedge clk);
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    measure(0, v, len);
    chk("ped_green_total", 32'(len + 2), 32'(MIN_GREEN));
    measure(2, v, len);
    chk("ped_walk_len", 32'(len), 32'(PED_T));

    // Emergency on the approach already green: green is held, no yellow.
    do_reset();
    car_req = 4'b0100;
    wait_gg(4'b0100);
    @(negedge clk);
    emergency = 1'b1; emergency_dir = 2'd2;
    @(negedge clk);
    chk("emerg_same_active", 32'(emergency_active), 32'd1);
    chk("emerg_same_green", 32'(grant_green), 32'h4);
    emergency_dir = 2'd0;
    repeat (3) @(negedge clk);
    chk("emerg_dir_ignored", 32'(grant_green), 32'h4);
    emergency = 1'b0;
    measure(1, v, len);
    chk("emerg_exit_yellow", 32'(v), 32'h4);
    chk("emerg_exit_ylen", 32'(len), 32'(YELLOW_T));

    // Emergency from another direction cuts the green short.
    do_reset();
    car_req = 4'b0001;
    wait_gg(4'b0001);
    @(negedge clk);
    emergency = 1'b1; emergency_dir = 2'd3;
    measure(1, v, len);
    chk("preempt_yellow", 32'(v), 32'h1);
    chk("preempt_ylen", 32'(len), 32'(YELLOW_T));
    for (int i = 0; i < 20 && !emergency_active; i++) @(negedge clk);
    chk("preempt_green", 32'(grant_green), 32'h8);
    emergency = 1'b0;
    repeat (4) @(negedge clk);

    // Reset in the middle of yellow.
    do_reset();
    car_req = 4'b0001;
    for (int i = 0; i < 40 && grant_yellow == 4'd0; i++) @(negedge clk);
    chk("midyellow_seen", 32'(grant_yellow), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    chk("midyellow_rst_green", 32'(grant_green), 32'd0);
    chk("midyellow_rst_yellow", 32'(grant_yellow), 32'd0);
    chk("midyellow_rst_phase", 32'(phase_state), 32'd0);
    reset = 1'b0;
    car_req = 4'b1111;
    measure(0, v, len);
    chk("post_rst_first", 32'(v), 32'h1);

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      reset   = ($urandom_range(0, 399) == 0);
      ped_req = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) car_req = 4'($urandom);
      if ($urandom_range(0, 24) == 0) emergency = ~emergency;
      if ($urandom_range(0, 3) == 0) emergency_dir = 2'($urandom);
    end
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
